// File: rtl/piso_tx8.sv
// piso_tx8: framed serial transmitter (start 0, data LSB first, stop 1).
// One frame per WIDTH+2 cycles; back-to-back loads leave no idle gap.
module piso_tx8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             res,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] LAST = CW'(WIDTH + 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t             state;
    logic [WIDTH+1:0]   frame;
    logic [CW-1:0]      cnt;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state <= IDLE;
            frame <= '1;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (load) begin
                        frame <= {1'b1, d, 1'b0};
                        cnt   <= '0;
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (cnt == LAST) begin
                        done <= 1'b1;
                        if (load) begin
                            frame <= {1'b1, d, 1'b0};
                            cnt   <= '0;
                        end else begin
                            frame <= '1;
                            cnt   <= '0;
                            state <= IDLE;
                        end
                    end else begin
                        frame <= {1'b1, frame[WIDTH+1:1]};
                        cnt   <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Frame register holds all 1s whenever idle, so bit 0 is the line directly.
    assign sout = frame[0];
    assign busy = (state == SEND);

endmodule

// File: tb/tb_piso_tx8.sv
// tb_piso_tx8: table vectors, directed corner sequences and a randomized
// cycle-trace reference for piso_tx8.
module tb_piso_tx8;

    logic       clk;
    logic       res;
    logic       load;
    logic [7:0] d;
    logic       sout;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    piso_tx8 #(.WIDTH(8)) dut (
        .clk  (clk),
        .res  (res),
        .load (load),
        .d    (d),
        .sout (sout),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    typedef struct {
        logic [7:0] dv;
        logic [9:0] line;
        bit         poke;
    } vec_t;

    typedef struct {
        logic       s;
        logic       b;
        logic       dn;
        logic       ld;
        logic [7:0] dv;
        logic       junk;
    } cyc_t;

    vec_t vecs[7];
    cyc_t tr[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] dv, input logic [9:0] line,
                              input bit poke, input string nm);
        load = 1'b1;
        d    = dv;
        tick();
        load = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk({nm, "_sout"}, sout, line[k]);
            chk({nm, "_busy"}, busy, 1'b1);
            chk({nm, "_done"}, done, 1'b0);
            if (poke) begin
                d    = 8'($urandom);
                load = (k == 5);
                if (k == 5) d = 8'hFF;
            end
            tick();
        end
        load = 1'b0;
        chk({nm, "_end_done"}, done, 1'b1);
        chk({nm, "_end_busy"}, busy, 1'b0);
        chk({nm, "_end_sout"}, sout, 1'b1);
        tick();
        chk({nm, "_post_done"}, done, 1'b0);
        chk({nm, "_post_sout"}, sout, 1'b1);
    endtask

    function automatic void push(input logic s, input logic b,
                                 input logic dn, input logic ld,
                                 input logic [7:0] dv, input logic junk);
        cyc_t c;
        c.s = s; c.b = b; c.dn = dn;
        c.ld = ld; c.dv = dv; c.junk = junk;
        tr.push_back(c);
    endfunction

    initial begin
        logic pend;
        logic [7:0] rd;
        int gap;

        vecs[0] = '{8'hA5, 10'b1101001010, 1'b0};
        vecs[1] = '{8'h3C, 10'b1001111000, 1'b1};
        vecs[2] = '{8'h5A, 10'b1010110100, 1'b1};
        vecs[3] = '{8'h00, 10'b1000000000, 1'b0};
        vecs[4] = '{8'hFF, 10'b1111111110, 1'b0};
        vecs[5] = '{8'h01, 10'b1000000010, 1'b0};
        vecs[6] = '{8'h80, 10'b1100000000, 1'b1};

        res  = 1'b0;
        load = 1'b0;
        d    = 8'h00;

        // async reset, mid-cycle, no edge
        @(posedge clk);
        #3;
        res = 1'b1;
        #1;
        chk("rst_async_sout", sout, 1'b1);
        chk("rst_async_busy", busy, 1'b0);
        chk("rst_async_done", done, 1'b0);
        load = 1'b1;
        d    = 8'h55;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_hold_sout", sout, 1'b1);
            chk("rst_hold_busy", busy, 1'b0);
            chk("rst_hold_done", done, 1'b0);
        end
        load = 1'b0;
        res  = 1'b0;
        tick();
        chk("idle_busy", busy, 1'b0);
        chk("idle_sout", sout, 1'b1);

        foreach (vecs[i])
            send_frame(vecs[i].dv, vecs[i].line, vecs[i].poke, "vec");

        // back-to-back: 01 then 80
        load = 1'b1;
        d    = 8'h01;
        tick();
        d = 8'h80;
        for (int c = 1; c <= 20; c++) begin
            chk("b2b_sout", sout,
                (c <= 10) ? vecs[5].line[c-1] : vecs[6].line[c-11]);
            chk("b2b_busy", busy, 1'b1);
            chk("b2b_done", done, (c == 11));
            if (c == 11) load = 1'b0;
            tick();
        end
        chk("b2b_end_done", done, 1'b1);
        chk("b2b_end_busy", busy, 1'b0);
        tick();
        chk("b2b_post_done", done, 1'b0);

        // reset during data bit 3 of 8'h00
        load = 1'b1;
        d    = 8'h00;
        tick();
        load = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("mid_pre_busy", busy, 1'b1);
        #2;
        res = 1'b1;
        #1;
        chk("mid_rst_sout", sout, 1'b1);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        tick();
        res = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("mid_no_done", done, 1'b0);
            chk("mid_idle_sout", sout, 1'b1);
        end
        send_frame(vecs[0].dv, vecs[0].line, 1'b0, "mid_after");

        // randomized frames against a per-cycle trace built from frame rules
        push(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        pend = 1'b0;
        for (int f = 0; f < 40; f++) begin
            rd  = 8'($urandom);
            gap = (f == 39) ? 2 : int'($urandom_range(0, 3));
            for (int k = 0; k < 10; k++) begin
                logic bitv;
                bitv = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : rd[k-1];
                push(bitv, 1'b1, (k == 0) && pend, (k == 0), rd, (k < 9));
            end
            pend = 1'b1;
            for (int j = 0; j < gap; j++) begin
                push(1'b1, 1'b0, pend, 1'b0, 8'h00, 1'b0);
                pend = 1'b0;
            end
        end
        for (int c = 0; c + 1 < tr.size(); c++) begin
            if (tr[c+1].ld) begin
                load = 1'b1;
                d    = tr[c+1].dv;
            end else if (tr[c].junk) begin
                load = 1'($urandom);
                d    = 8'($urandom);
            end else begin
                load = 1'b0;
                d    = 8'($urandom);
            end
            tick();
            chk("rnd_sout", sout, tr[c+1].s);
            chk("rnd_busy", busy, tr[c+1].b);
            chk("rnd_done", done, tr[c+1].dn);
        end
        load = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/piso_tx8.md
# piso_tx8

Serial frame transmitter: accepts a parallel data word on a one-cycle load strobe and shifts it out on a single line as a framed serial stream. Each frame is start bit (0), data LSB first, stop bit (1). The block is the sending end of the lab's serial link and pairs with the serial-in/parallel-out receiver on the other side of the same line. All storage is rising-edge flip-flops with asynchronous active-high reset.

## Interface

Parameters:
- WIDTH, 8, data bits per frame; frame length is WIDTH+2 bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- res  input  1  reset, asynchronous, active-high.
- load  input  1  start request; sampled on the rising edge of clk.
- d  input  WIDTH  parallel data; captured on the accepting edge only.
- sout  output  1  serial line; idles high.
- busy  output  1  high while a frame is in flight.
- done  output  1  one-cycle pulse after the stop bit completes.

## Operation

- Reset (res=1, asynchronous, takes effect without a clock edge):
  - sout=1, busy=0, done=0.
  - Frame shift register cleared to all 1s; bit counter cleared to 0.
  - An in-flight frame is aborted. No done pulse for it.
  - After res falls, the block is IDLE.
- States: IDLE (busy=0) and SEND (busy=1). The bit counter runs 0..WIDTH+1.
- IDLE:
  - sout=1.
  - On an edge with load=1, the frame register loads {1, d, 0} (bit 0 = start), counter=0, and the block enters SEND.
- SEND:
  - sout = frame register bit 0, driven combinationally from the register output with no added delay.
  - Each edge shifts the register right by one, filling with 1, and increments the counter.
- End of frame (counter = WIDTH+1, stop bit on the line):
  - With load=0 at the next edge: return to IDLE, busy=0, done=1 for exactly one cycle.
  - With load=1 at the next edge: back-to-back. Load new {1, d, 0}, counter=0, stay in SEND, busy stays 1, and done still pulses for one cycle.
- load in SEND with counter < WIDTH+1 is ignored: no capture, no error, and d is don't-care.
- d is sampled only on the accepting edge. Later changes to d do not affect the frame in flight.
- Counter width is ceil(log2(WIDTH+2)) bits. The counter never exceeds WIDTH+1.

## Timing

- Accepting edge is E0. Line values:
  - Start bit in the cycle after E0.
  - Data bit i in the cycle after edge E(i+1).
  - Stop bit in the cycle after E(WIDTH+1).
- Latency: load sampled to start bit on sout is 1 cycle.
- Line occupancy: WIDTH+2 cycles per frame.
- busy rises after E0 and falls after E(WIDTH+2) unless the frame is back-to-back.
- done is high in the cycle after E(WIDTH+2), i.e. the first idle cycle or the start-bit cycle of a back-to-back frame.
- Back-to-back throughput is one frame per WIDTH+2 cycles, with no idle gap between stop and start.
- sout has no glitches at register transitions; it changes only after clock edges or asynchronous reset.

## Test plan

- Reset values:
  - Assert res mid-cycle with no clock edge: sout=1, busy=0, done=0 immediately.
  - Hold res for 3 edges with load=1: the outputs stay at those values.
- Single frame:
  - load=1 for one edge with d=8'hA5 (WIDTH=8).
  - sout over the next 10 cycles: 0,1,0,1,0,0,1,0,1,1.
  - busy high for those 10 cycles, done=1 in cycle 11 only, then sout=1.
- Ignored load:
  - Start a frame with d=8'h3C.
  - Pulse load with d=8'hFF during data bit 4.
  - Sequence is unchanged: 0,0,0,1,1,1,1,0,0,1. Exactly one done pulse.
- Back-to-back:
  - Hold load=1 continuously, with d=8'h01 then 8'h80 at the two accepting edges.
  - sout: 0,1,0,0,0,0,0,0,0,1,0,0,0,0,0,0,0,0,1,1.
  - busy never drops between the two frames. done pulses in cycle 11 and cycle 21.
- Reset mid-frame:
  - Assert res during data bit 3 of d=8'h00: sout=1 and busy=0 at once. No done pulse ever appears for that frame.
  - A new load after res falls produces a complete, correct frame.
- Data stability:
  - Change d every cycle after the accepting edge of d=8'h5A.
  - sout is still 0,0,1,0,1,1,0,1,0,1.
